// File: rtl/demux14_stream.sv
// 1-to-4 stream demultiplexer with a one-entry holding register and handshake per lane.
// Define DEMUX14_CNT_EN to add per-lane drain counters on the lane_cnt port.
module demux14_stream #(
  parameter int unsigned W     = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [4*W-1:0]   out_data
`ifdef DEMUX14_CNT_EN
  ,
  output logic [4*CNT_W-1:0] lane_cnt
`endif
);

  localparam int unsigned NumLanes = 4;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } lane_st_e;

  lane_st_e             st_q   [NumLanes];
  lane_st_e             st_d   [NumLanes];
  logic     [W-1:0]     data_q [NumLanes];
  logic     [W-1:0]     data_d [NumLanes];

  logic                 sel_free;
  logic                 accept;
  logic [NumLanes-1:0]  load;
  logic [NumLanes-1:0]  drain;

  // A lane can take a word if it is empty or is being emptied this same cycle.
  always_comb begin
    sel_free = 1'b0;
    unique case (in_sel)
      2'd0:    sel_free = ~out_valid[0] | out_ready[0];
      2'd1:    sel_free = ~out_valid[1] | out_ready[1];
      2'd2:    sel_free = ~out_valid[2] | out_ready[2];
      2'd3:    sel_free = ~out_valid[3] | out_ready[3];
      default: sel_free = 1'b0;
    endcase
  end

  assign in_ready = ~rst & sel_free;
  assign accept   = in_valid & in_ready;

  always_comb begin
    load  = '0;
    drain = '0;
    for (int k = 0; k < NumLanes; k++) begin
      load[k]  = accept & (in_sel == 2'(k));
      drain[k] = out_valid[k] & out_ready[k];
    end
  end

  // Lane FSMs: drain only clears valid, the held word stays on out_data.
  always_comb begin
    for (int k = 0; k < NumLanes; k++) begin
      st_d[k]   = st_q[k];
      data_d[k] = data_q[k];
      unique case (st_q[k])
        StEmpty: begin
          if (load[k]) begin
            st_d[k]   = StFull;
            data_d[k] = in_data;
          end
        end
        StFull: begin
          if (load[k]) begin
            st_d[k]   = StFull;
            data_d[k] = in_data;
          end else if (drain[k]) begin
            st_d[k] = StEmpty;
          end
        end
        default: begin
          st_d[k] = StEmpty;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NumLanes; k++) begin
        st_q[k]   <= StEmpty;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumLanes; k++) begin
        st_q[k]   <= st_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < NumLanes; k++) begin
      out_valid[k]       = (st_q[k] == StFull);
      out_data[k*W +: W] = data_q[k];
    end
  end

`ifdef DEMUX14_CNT_EN
  logic [CNT_W-1:0] cnt_q [NumLanes];
  logic [CNT_W-1:0] cnt_d [NumLanes];

  // Plain modulo counters; reset wins so a drain in the reset cycle is not counted.
  always_comb begin
    for (int k = 0; k < NumLanes; k++) begin
      cnt_d[k] = cnt_q[k];
      if (drain[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NumLanes; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumLanes; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_comb begin
    lane_cnt = '0;
    for (int k = 0; k < NumLanes; k++) begin
      lane_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
